lvda_phase_gen: RTL and testbench

Parametrised LVDA timing-phase generator. It derives the W/X/Y/Z-style phase pulses from SIM_CLK and drives each phase through FANOUT replicated register copies, so phase fan-out comes from one block instead of separately supplied phase inputs. Phase count, pulse length, dead time and fan-out are all configurable. The block adds run/stop control, resynchronisation and a cycle strobe, and sits at the head of the LVDA timing chain.

---
 rtl/lvda_timing_pkg.sv | 25 ++
 rtl/lvda_phase_drv.sv | 23 ++
 rtl/lvda_phase_gen.sv | 138 +++++++++++++
 tb/tb_lvda_phase_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lvda_timing_pkg.sv
// Shared types and sizing helpers for the LVDA timing-phase generator.
package lvda_timing_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  // Down-counter width: enough for the longer of phase and gap, plus one bit.
  function automatic int unsigned cnt_width(input int unsigned phase_len,
                                            input int unsigned gap_len);
    int unsigned m;
    m = 1;
    if (phase_len > m) m = phase_len;
    if (gap_len > m) m = gap_len;
    return $unsigned($clog2(m)) + 1;
  endfunction

  // Phase index width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned num_phases);
    return (num_phases > 1) ? $unsigned($clog2(num_phases)) : 1;
  endfunction

endpackage

// File: rtl/lvda_phase_drv.sv
// Replicated driver bank: FANOUT independent flops carrying one phase.
module lvda_phase_drv #(
  parameter int unsigned FANOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d,
  output logic [FANOUT-1:0] q
);

  for (genvar c = 0; c < FANOUT; c++) begin : g_copy
    (* keep *) logic copy;

    // One separately kept flop per driver copy.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) copy <= 1'b0;
      else        copy <= d;
    end

    assign q[c] = copy;
  end

endmodule

// File: rtl/lvda_phase_gen.sv
// LVDA timing-phase generator: sequences W/X/Y/Z-style phases with dead time,
// run/stop, resync and a cycle strobe. Optional single-step via macro STEP_EN.
module lvda_phase_gen
  import lvda_timing_pkg::*;
#(
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned FANOUT     = 8,
  parameter int unsigned PHASE_LEN  = 4,
  parameter int unsigned GAP_LEN    = 1
) (
  input  logic                               SIM_CLK,
  input  logic                               SIM_RST,
  input  logic                               RUN,
  input  logic                               SYNC,
`ifdef STEP_EN
  input  logic                               STEP,
`endif
  output logic [NUM_PHASES*FANOUT-1:0]       PHASE,
  output logic [idx_width(NUM_PHASES)-1:0]   PHASE_IDX,
  output logic                               CYCLE_STB,
  output logic                               BUSY
);

  localparam int unsigned CW = cnt_width(PHASE_LEN, GAP_LEN);
  localparam int unsigned IW = idx_width(NUM_PHASES);
  localparam logic [CW-1:0] PHASE_LOAD = CW'(PHASE_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD   = (GAP_LEN > 0) ? CW'(GAP_LEN - 1) : CW'(0);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_PHASES - 1);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   idx, idx_n;
  logic            stb, stb_n;
  logic            busy;
  logic            sync_gap, sync_gap_n;
  logic            start;
  logic            end_gap;
  logic            wrap;
  logic [NUM_PHASES-1:0] phase_n;

`ifdef STEP_EN
  assign start = RUN | STEP;
`else
  assign start = RUN;
`endif

  assign wrap = (idx == LAST_IDX);

  // State, counter, index and status registers.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      stb      <= 1'b0;
      busy     <= 1'b0;
      sync_gap <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      stb      <= stb_n;
      busy     <= (state_n != IDLE);
      sync_gap <= sync_gap_n;
    end
  end

  // Next-state logic; a resync gap suppresses the strobe on its wrap.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    stb_n      = 1'b0;
    sync_gap_n = sync_gap;
    end_gap    = 1'b0;
    phase_n    = '0;

    if (SYNC) begin
      state_n    = GAP;
      cnt_n      = GAP_LOAD;
      idx_n      = LAST_IDX;
      sync_gap_n = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n = ACTIVE;
            cnt_n   = PHASE_LOAD;
          end
        end
        ACTIVE: begin
          if (cnt != '0) begin
            cnt_n = cnt - CW'(1);
          end else if (GAP_LEN > 0) begin
            state_n = GAP;
            cnt_n   = GAP_LOAD;
          end else begin
            end_gap = 1'b1;
          end
        end
        GAP: begin
          if (cnt != '0) cnt_n = cnt - CW'(1);
          else           end_gap = 1'b1;
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase

      if (end_gap) begin
        idx_n      = wrap ? '0 : idx + IW'(1);
        stb_n      = wrap & ~sync_gap;
        sync_gap_n = 1'b0;
        state_n    = RUN ? ACTIVE : IDLE;
        cnt_n      = RUN ? PHASE_LOAD : '0;
      end
    end

    for (int unsigned p = 0; p < NUM_PHASES; p++) begin
      phase_n[p] = (state_n == ACTIVE) && (idx_n == IW'(p));
    end
  end

  for (genvar p = 0; p < NUM_PHASES; p++) begin : g_phase
    lvda_phase_drv #(.FANOUT(FANOUT)) u_drv (
      .clk   (SIM_CLK),
      .rst_n (SIM_RST),
      .d     (phase_n[p]),
      .q     (PHASE[p*FANOUT +: FANOUT])
    );
  end

  assign PHASE_IDX = idx;
  assign CYCLE_STB = stb;
  assign BUSY      = busy;

endmodule

// File: tb/tb_lvda_phase_gen.sv
// Directed bench for lvda_phase_gen with a per-cycle expectation queue.
module tb_lvda_phase_gen;

  typedef struct {
    string       tag;
    logic [31:0] phase;
    logic [1:0]  idx;
    logic        stb;
    logic        busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run, sync;
  logic        run2, sync2;
  logic        step, step2;
  logic [31:0] phase;
  logic [1:0]  idx;
  logic        stb, busy;
  logic [15:0] phase2;
  logic [0:0]  idx2;
  logic        stb2, busy2;

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  lvda_phase_gen #(.NUM_PHASES(4), .FANOUT(8), .PHASE_LEN(4), .GAP_LEN(1)) u_dut (
    .SIM_CLK   (clk),
    .SIM_RST   (rst_n),
    .RUN       (run),
    .SYNC      (sync),
`ifdef STEP_EN
    .STEP      (step),
`endif
    .PHASE     (phase),
    .PHASE_IDX (idx),
    .CYCLE_STB (stb),
    .BUSY      (busy)
  );

  lvda_phase_gen #(.NUM_PHASES(2), .FANOUT(8), .PHASE_LEN(1), .GAP_LEN(0)) u_fast (
    .SIM_CLK   (clk),
    .SIM_RST   (rst_n),
    .RUN       (run2),
    .SYNC      (sync2),
`ifdef STEP_EN
    .STEP      (step2),
`endif
    .PHASE     (phase2),
    .PHASE_IDX (idx2),
    .CYCLE_STB (stb2),
    .BUSY      (busy2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pv(input int p);
    logic [31:0] v;
    v = 32'h0000_00FF;
    if (p < 0) return 32'h0;
    return v << (p * 8);
  endfunction

  task automatic push(input string tag, input int p, input int i, input bit s, input bit b);
    exp_t e;
    e.tag = tag; e.phase = pv(p); e.idx = 2'(i); e.stb = s; e.busy = b;
    sb.push_back(e);
  endtask

  // Four high clocks of phase p followed by one dead clock.
  task automatic push_phase(input string tag, input int p, input bit first_stb);
    push(tag, p, p, first_stb, 1'b1);
    for (int k = 0; k < 3; k++) push(tag, p, p, 1'b0, 1'b1);
    push({tag, "_gap"}, -1, p, 1'b0, 1'b1);
  endtask

  task automatic tick_n(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, "_phase"}, 64'(phase), 64'(e.phase));
        check({e.tag, "_idx"},   64'(idx),   64'(e.idx));
        check({e.tag, "_stb"},   64'(stb),   64'(e.stb));
        check({e.tag, "_busy"},  64'(busy),  64'(e.busy));
      end
    end
  endtask

  initial begin
    int nstb;
    int last;
    int start_idx;
    logic [3:0] any;
    logic copies_ok;

    rst_n = 1'b0; run = 1'b1; sync = 1'b0; run2 = 1'b0; sync2 = 1'b0;
    step = 1'b0; step2 = 1'b0;

    // Reset held with RUN high: everything stays cleared.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rst_phase", 64'(phase), 64'h0);
      check("rst_idx",   64'(idx),   64'h0);
      check("rst_stb",   64'(stb),   64'h0);
      check("rst_busy",  64'(busy),  64'h0);
    end
    @(negedge clk); rst_n = 1'b1;

    // First full cycle, then phase 0 with the cycle strobe.
    push_phase("c0p0", 0, 1'b0);
    push_phase("c0p1", 1, 1'b0);
    push_phase("c0p2", 2, 1'b0);
    push_phase("c0p3", 3, 1'b0);
    push("c1p0", 0, 0, 1'b1, 1'b1);
    tick_n(21);

    // Free run: strobe spacing, one-hot phases, identical copies.
    nstb = 0; last = 0;
    for (int k = 1; k <= 100; k++) begin
      tick_n(1);
      copies_ok = 1'b1;
      for (int p = 0; p < 4; p++) begin
        any[p] = |phase[p*8 +: 8];
        if (phase[p*8 +: 8] != 8'h00 && phase[p*8 +: 8] != 8'hFF) copies_ok = 1'b0;
      end
      check("copies_equal", 64'(copies_ok), 64'h1);
      check("one_hot", 64'($countones(any) <= 1), 64'h1);
      if (stb === 1'b1) begin
        nstb++;
        check("stb_interval", 64'(k - last), 64'd20);
        last = k;
      end
    end
    check("stb_count", 64'(nstb), 64'd5);

    // Advance to phase 2 clock 1, then drop RUN.
    tick_n(10);
    check("p2_clk1", 64'(phase), 64'(pv(2)));
    run = 1'b0;
    for (int k = 0; k < 3; k++) push("drop_p2", 2, 2, 1'b0, 1'b1);
    push("drop_gap", -1, 2, 1'b0, 1'b1);
    push("drop_idle", -1, 3, 1'b0, 1'b0);
    push("drop_idle", -1, 3, 1'b0, 1'b0);
    tick_n(6);
    run = 1'b1;
    push_phase("resume_p3", 3, 1'b0);
    push("resume_p0", 0, 0, 1'b1, 1'b1);
    tick_n(6);

    // SYNC during phase 1: one dead clock, then phase 0 with no strobe.
    for (int k = 0; k < 3; k++) push("pre_p0", 0, 0, 1'b0, 1'b1);
    push("pre_gap", -1, 0, 1'b0, 1'b1);
    push("pre_p1", 1, 1, 1'b0, 1'b1);
    tick_n(5);
    sync = 1'b1;
    push("sync_gap", -1, 3, 1'b0, 1'b1);
    tick_n(1);
    sync = 1'b0;
    push_phase("sync_p0", 0, 1'b0);
    push_phase("sync_p1", 1, 1'b0);
    push_phase("sync_p2", 2, 1'b0);
    push_phase("sync_p3", 3, 1'b0);
    push("sync_wrap", 0, 0, 1'b1, 1'b1);
    tick_n(21);

    // Asynchronous reset mid-pulse clears PHASE immediately.
    tick_n(2);
    check("pre_rst_phase", 64'(phase), 64'(pv(0)));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_phase", 64'(phase), 64'h0);
    check("async_rst_busy",  64'(busy),  64'h0);
    check("async_rst_idx",   64'(idx),   64'h0);
    run = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    push("post_rst_idle", -1, 0, 1'b0, 1'b0);
    push("post_rst_idle", -1, 0, 1'b0, 1'b0);
    tick_n(2);

    start_idx = 0;
`ifdef STEP_EN
    // Single step: one phase plus gap; a STEP while busy is ignored.
    step = 1'b1;
    push("step_p0", 0, 0, 1'b0, 1'b1);
    tick_n(1);
    step = 1'b0;
    push("step_p0", 0, 0, 1'b0, 1'b1);
    tick_n(1);
    step = 1'b1;
    push("step_p0", 0, 0, 1'b0, 1'b1);
    tick_n(1);
    step = 1'b0;
    push("step_p0", 0, 0, 1'b0, 1'b1);
    push("step_gap", -1, 0, 1'b0, 1'b1);
    push("step_idle", -1, 1, 1'b0, 1'b0);
    push("step_idle", -1, 1, 1'b0, 1'b0);
    tick_n(5);
    start_idx = 1;
`endif

    // RUN after reset starts at the held index on the next edge.
    run = 1'b1;
    push("run_start", start_idx, start_idx, 1'b0, 1'b1);
    tick_n(1);
    run = 1'b0;

    // Back-to-back phases with no dead time.
    run2 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick_n(1);
      check("fast_phase", 64'(phase2), (k % 2 == 0) ? 64'h00FF : 64'hFF00);
      check("fast_idx",   64'(idx2),   64'(k % 2));
      check("fast_stb",   64'(stb2),   64'(k >= 2 && k % 2 == 0));
    end
    sync2 = 1'b1;
    tick_n(1);
    sync2 = 1'b0;
    check("fast_sync_phase", 64'(phase2), 64'h0);
    check("fast_sync_idx",   64'(idx2),   64'h1);
    check("fast_sync_busy",  64'(busy2),  64'h1);
    tick_n(1);
    check("fast_after_sync_phase", 64'(phase2), 64'h00FF);
    check("fast_after_sync_stb",   64'(stb2),   64'h0);
    tick_n(1);
    check("fast_after_sync_p1", 64'(phase2), 64'hFF00);
    tick_n(1);
    check("fast_wrap_phase", 64'(phase2), 64'h00FF);
    check("fast_wrap_stb",   64'(stb2),   64'h1);

    check("queue_drained", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
